// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: the requester id stored in the
// read-return FIFO and the fixed number of requesters.
package sram_arb_pkg;
    localparam int NUM_PORTS = 2;
    typedef logic port_id_t;
endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of requester ids for outstanding reads; the head is visible
// combinationally (first-word-fall-through) so returns can be routed at once.
module sram_arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  port_id_t push_id_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output port_id_t head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    port_id_t         id_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = id_mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            id_mem_q[wr_ptr_q] <= push_id_i;
    end
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one sram_controller between two requesters;
// write completions and read data are steered back to the issuing port.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16,
    parameter int MAX_READS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p0_req,
    output logic                 p0_ready,
    input  logic                 p0_write_enable,
    input  logic [ADDR_BITS-1:0] p0_addr,
    input  logic [DATA_BITS-1:0] p0_write_data,
    output logic                 p0_write_done,
    output logic [DATA_BITS-1:0] p0_read_data,
    output logic                 p0_read_data_valid,
    input  logic                 p1_req,
    output logic                 p1_ready,
    input  logic                 p1_write_enable,
    input  logic [ADDR_BITS-1:0] p1_addr,
    input  logic [DATA_BITS-1:0] p1_write_data,
    output logic                 p1_write_done,
    output logic [DATA_BITS-1:0] p1_read_data,
    output logic                 p1_read_data_valid,
    output logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 mem_write_enable,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_done,
    input  logic [DATA_BITS-1:0] mem_read_data,
    input  logic                 mem_read_data_valid
);
    logic [NUM_PORTS-1:0] req_a, we_a, elig, ready_a, wdone_a, rvalid_a;
    port_id_t             last_grant_q, last_grant_d;
    port_id_t             wr_port_q, wr_port_d;
    port_id_t             winner, rd_head;
    logic                 grant_valid, winner_we;
    logic                 rd_full, rd_empty, rd_push, rd_pop;

    assign req_a = {p1_req, p0_req};
    assign we_a  = {p1_write_enable, p0_write_enable};

    // Reads are held off while the id FIFO is full, even if it pops this cycle.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign elig[gi]     = req_a[gi] && (we_a[gi] || !rd_full);
            assign ready_a[gi]  = grant_valid && (winner == port_id_t'(gi));
            assign wdone_a[gi]  = !reset && mem_write_done && (wr_port_q == port_id_t'(gi));
            assign rvalid_a[gi] = rd_pop && (rd_head == port_id_t'(gi));
        end
    endgenerate

    always_comb begin
        winner = 1'b0;
        if (elig[0] && elig[1])
            winner = ~last_grant_q;
        else if (elig[1])
            winner = 1'b1;
    end

    assign grant_valid = mem_ready && !reset && (|elig);
    assign winner_we   = winner ? p1_write_enable : p0_write_enable;

    assign mem_req          = grant_valid;
    assign mem_write_enable = grant_valid && winner_we;
    assign mem_addr         = !grant_valid ? '0 : (winner ? p1_addr : p0_addr);
    assign mem_write_data   = !grant_valid ? '0 : (winner ? p1_write_data : p0_write_data);

    assign rd_push = grant_valid && !winner_we;
    assign rd_pop  = mem_read_data_valid && !rd_empty && !reset;

    always_comb begin
        last_grant_d = last_grant_q;
        wr_port_d    = wr_port_q;
        if (grant_valid) begin
            last_grant_d = winner;
            if (winner_we)
                wr_port_d = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            wr_port_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_port_q    <= wr_port_d;
        end
    end

    sram_arb_id_fifo #(
        .DEPTH(MAX_READS)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (rd_push),
        .push_id_i (winner),
        .pop_i     (rd_pop),
        .full_o    (rd_full),
        .empty_o   (rd_empty),
        .head_o    (rd_head)
    );

    assign p0_ready           = ready_a[0];
    assign p1_ready           = ready_a[1];
    assign p0_write_done      = wdone_a[0];
    assign p1_write_done      = wdone_a[1];
    assign p0_read_data_valid = rvalid_a[0];
    assign p1_read_data_valid = rvalid_a[1];
    assign p0_read_data       = mem_read_data;
    assign p1_read_data       = mem_read_data;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; the controller side is driven by hand so
// each grant, completion and read return lands on a known cycle.
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_ready, p0_write_enable, p0_write_done, p0_read_data_valid;
    logic [19:0] p0_addr;
    logic [15:0] p0_write_data, p0_read_data;
    logic        p1_req, p1_ready, p1_write_enable, p1_write_done, p1_read_data_valid;
    logic [19:0] p1_addr;
    logic [15:0] p1_write_data, p1_read_data;
    logic        mem_req, mem_ready, mem_write_enable, mem_write_done, mem_read_data_valid;
    logic [19:0] mem_addr;
    logic [15:0] mem_write_data, mem_read_data;

    int checks = 0;
    int failures = 0;
    int n0, n1;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .MAX_READS(4)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_ready(p0_ready), .p0_write_enable(p0_write_enable),
        .p0_addr(p0_addr), .p0_write_data(p0_write_data), .p0_write_done(p0_write_done),
        .p0_read_data(p0_read_data), .p0_read_data_valid(p0_read_data_valid),
        .p1_req(p1_req), .p1_ready(p1_ready), .p1_write_enable(p1_write_enable),
        .p1_addr(p1_addr), .p1_write_data(p1_write_data), .p1_write_done(p1_write_done),
        .p1_read_data(p1_read_data), .p1_read_data_valid(p1_read_data_valid),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_write_enable(mem_write_enable),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write_done(mem_write_done),
        .mem_read_data(mem_read_data), .mem_read_data_valid(mem_read_data_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req = 0; p0_write_enable = 0; p0_addr = '0; p0_write_data = '0;
        p1_req = 0; p1_write_enable = 0; p1_addr = '0; p1_write_data = '0;
        mem_write_done = 0; mem_read_data_valid = 0; mem_read_data = '0;
    endtask

    initial begin
        idle();
        mem_ready = 1'b1;
        reset = 1'b1;
        tick(); tick();
        // Requests and a stray return during reset must all be ignored
        p0_req = 1; mem_read_data_valid = 1; mem_read_data = 16'h5A5A;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_p0_ready", p0_ready, 0);
        chk("rst_p1_ready", p1_ready, 0);
        chk("rst_p0_rvalid", p0_read_data_valid, 0);
        chk("rst_p1_rvalid", p1_read_data_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        tick();
        reset = 0; idle();

        // 1: single write from p0
        p0_req = 1; p0_write_enable = 1; p0_addr = 20'h00010; p0_write_data = 16'hBEEF;
        #1;
        chk("t1_p0_ready", p0_ready, 1);
        chk("t1_p1_ready", p1_ready, 0);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_we", mem_write_enable, 1);
        chk("t1_mem_addr", mem_addr, 20'h00010);
        chk("t1_mem_wdata", mem_write_data, 16'hBEEF);
        tick();
        idle(); mem_write_done = 1;
        #1;
        chk("t1_p0_wdone", p0_write_done, 1);
        chk("t1_p1_wdone", p1_write_done, 0);
        chk("t1_mem_req_idle", mem_req, 0);
        tick();
        mem_write_done = 0;
        #1;
        chk("t1_p0_wdone_end", p0_write_done, 0);

        // 2: both ports read continuously; reset first so port 0 wins the first tie
        reset = 1; tick(); reset = 0;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 9; i++) begin
            p0_req = (i < 8); p1_req = (i < 8);
            p0_write_enable = 0; p1_write_enable = 0;
            p0_addr = 20'h00100 + 20'(i); p1_addr = 20'h00200 + 20'(i);
            mem_read_data_valid = (i >= 1); mem_read_data = 16'hA000 + 16'(i);
            #1;
            if (i < 8) begin
                chk($sformatf("t2_p0_ready_%0d", i), p0_ready, (i % 2) == 0);
                chk($sformatf("t2_p1_ready_%0d", i), p1_ready, (i % 2) == 1);
                chk($sformatf("t2_mem_addr_%0d", i), mem_addr,
                    (i % 2) == 0 ? 20'h00100 + 20'(i) : 20'h00200 + 20'(i));
            end
            if (i >= 1) begin
                chk($sformatf("t2_p0_rvalid_%0d", i), p0_read_data_valid, ((i - 1) % 2) == 0);
                chk($sformatf("t2_p1_rvalid_%0d", i), p1_read_data_valid, ((i - 1) % 2) == 1);
            end
            if (p0_read_data_valid === 1'b1) n0++;
            if (p1_read_data_valid === 1'b1) n1++;
            tick();
        end
        idle();
        chk("t2_p0_count", n0, 4);
        chk("t2_p1_count", n1, 4);

        // 3: p0 read vs p1 write, then p1 reads back; last grant was port 1
        p0_req = 1; p0_write_enable = 0; p0_addr = 20'h00010;
        p1_req = 1; p1_write_enable = 1; p1_addr = 20'h00020; p1_write_data = 16'h1234;
        #1;
        chk("t3_p0_ready", p0_ready, 1);
        chk("t3_p1_ready", p1_ready, 0);
        tick();
        p0_req = 0;
        #1;
        chk("t3_p1_wr_ready", p1_ready, 1);
        chk("t3_mem_wdata", mem_write_data, 16'h1234);
        tick();
        p1_write_enable = 0; p1_addr = 20'h00020;
        mem_read_data_valid = 1; mem_read_data = 16'hBEEF;
        #1;
        chk("t3_p1_rd_ready", p1_ready, 1);
        chk("t3_p0_rvalid", p0_read_data_valid, 1);
        chk("t3_p1_rvalid_no", p1_read_data_valid, 0);
        chk("t3_p0_rdata", p0_read_data, 16'hBEEF);
        tick();
        idle();
        mem_write_done = 1; mem_read_data_valid = 1; mem_read_data = 16'h1234;
        #1;
        chk("t3_p1_wdone", p1_write_done, 1);
        chk("t3_p0_wdone_no", p0_write_done, 0);
        chk("t3_p1_rvalid", p1_read_data_valid, 1);
        chk("t3_p0_rvalid_no", p0_read_data_valid, 0);
        chk("t3_p1_rdata", p1_read_data, 16'h1234);
        tick();
        idle();

        // 4: four outstanding reads fill the id FIFO
        for (int k = 0; k < 4; k++) begin
            p0_req = 1; p0_write_enable = 0; p0_addr = 20'h00300 + 20'(k);
            #1;
            chk($sformatf("t4_fill_ready_%0d", k), p0_ready, 1);
            tick();
        end
        p1_req = 1; p1_write_enable = 1; p1_addr = 20'h00040; p1_write_data = 16'h7777;
        #1;
        chk("t4_full_p0_ready", p0_ready, 0);
        chk("t4_full_p1_ready", p1_ready, 1);
        chk("t4_full_mem_we", mem_write_enable, 1);
        chk("t4_full_mem_addr", mem_addr, 20'h00040);
        tick();
        p1_req = 0; p1_write_enable = 0;
        mem_read_data_valid = 1; mem_read_data = 16'h3000;
        #1;
        chk("t4_pop_p0_ready", p0_ready, 0);
        chk("t4_pop_mem_req", mem_req, 0);
        chk("t4_pop_p0_rvalid", p0_read_data_valid, 1);
        tick();
        mem_read_data = 16'h3001;
        #1;
        chk("t4_reopen_p0_ready", p0_ready, 1);
        chk("t4_reopen_p0_rvalid", p0_read_data_valid, 1);
        tick();
        p0_req = 0;
        for (int k = 0; k < 3; k++) begin
            mem_read_data_valid = 1; mem_read_data = 16'h3002 + 16'(k);
            mem_write_done = (k == 0);
            #1;
            chk($sformatf("t4_drain_p0_rvalid_%0d", k), p0_read_data_valid, 1);
            chk($sformatf("t4_drain_p1_rvalid_%0d", k), p1_read_data_valid, 0);
            chk($sformatf("t4_drain_p1_wdone_%0d", k), p1_write_done, k == 0);
            tick();
        end

        // 6: return with the FIFO empty is dropped
        mem_write_done = 0; mem_read_data_valid = 1; mem_read_data = 16'hDEAD;
        #1;
        chk("t6_p0_rvalid", p0_read_data_valid, 0);
        chk("t6_p1_rvalid", p1_read_data_valid, 0);
        tick();
        idle();

        // 5: reset one cycle after a read is accepted discards that read
        p0_req = 1; p0_write_enable = 0; p0_addr = 20'h00010;
        #1;
        chk("t5_p0_ready", p0_ready, 1);
        tick();
        p0_req = 0;
        reset = 1; mem_read_data_valid = 1; mem_read_data = 16'hBEEF;
        #1;
        chk("t5_rst_p0_rvalid", p0_read_data_valid, 0);
        chk("t5_rst_p1_rvalid", p1_read_data_valid, 0);
        tick();
        reset = 0;
        #1;
        chk("t5_post_p0_rvalid", p0_read_data_valid, 0);
        chk("t5_post_p1_rvalid", p1_read_data_valid, 0);
        tick();
        mem_read_data_valid = 0;
        p1_req = 1; p1_write_enable = 0; p1_addr = 20'h00020;
        #1;
        chk("t5_p1_ready", p1_ready, 1);
        tick();
        p1_req = 0; mem_read_data_valid = 1; mem_read_data = 16'h1234;
        #1;
        chk("t5_p1_rvalid", p1_read_data_valid, 1);
        chk("t5_p0_rvalid", p0_read_data_valid, 0);
        chk("t5_p1_rdata", p1_read_data, 16'h1234);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
